// File: rtl/line_window_gen_pkg.sv
// Shared types and geometry helpers for the sliding-window generator.
package line_window_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_EMIT,
    ST_DRAIN
  } state_t;

  function automatic int out_dim(input int in_dim, input int k, input int d,
                                 input int p, input int s);
    return (in_dim + 2 * p - d * (k - 1) - 1) / s + 1;
  endfunction

  function automatic int lines_of(input int k, input int d);
    return d * (k - 1) + 2;
  endfunction

  function automatic int kernel_pts(input int k0, input int k1);
    return k0 * k1;
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Circular line store: one write port, one combinational read port per kernel point.
module line_buffer_ram #(
  parameter int DW    = 24,
  parameter int LINES = 6,
  parameter int DEPTH = 513,
  parameter int NRD   = 9,
  parameter int SW    = 3,
  parameter int CW    = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [SW-1:0] i_wr_slot,
  input  logic [CW-1:0] i_wr_col,
  input  logic [DW-1:0] i_wr_data,
  input  logic [SW-1:0] i_rd_slot [NRD],
  input  logic [CW-1:0] i_rd_col  [NRD],
  output logic [DW-1:0] o_rd_data [NRD]
);

  logic [DW-1:0] r_mem [LINES][DEPTH];

  // NOTE: the storage array has no reset; every location is written before it is read in a frame.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_slot][i_wr_col] <= i_wr_data;
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) o_rd_data[i] = r_mem[i_rd_slot[i]][i_rd_col[i]];
  end

endmodule

// File: rtl/line_window_gen.sv
// Raster pixel stream in, zero-padded dilated/strided convolution windows out.
module line_window_gen
  import line_window_gen_pkg::*;
#(
  parameter int IN_WIDTH   = 513,
  parameter int IN_HEIGHT  = 257,
  parameter int IN_CHANNEL = 3,
  parameter int KERNEL_0   = 3,
  parameter int KERNEL_1   = 3,
  parameter int DILATION_0 = 2,
  parameter int DILATION_1 = 2,
  parameter int PADDING_0  = 2,
  parameter int PADDING_1  = 2,
  parameter int STRIDE_0   = 1,
  parameter int STRIDE_1   = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [8*IN_CHANNEL-1:0]                    i_data,
  input  logic                                       i_valid,
  output logic                                       i_ready,
  output logic [8*IN_CHANNEL*KERNEL_0*KERNEL_1-1:0]  o_data,
  output logic                                       o_valid,
  input  logic                                       pe_ack,
  output logic                                       frame_done
);

  localparam int DW    = 8 * IN_CHANNEL;
  localparam int KP    = kernel_pts(KERNEL_0, KERNEL_1);
  localparam int OUT_H = out_dim(IN_HEIGHT, KERNEL_0, DILATION_0, PADDING_0, STRIDE_0);
  localparam int OUT_W = out_dim(IN_WIDTH, KERNEL_1, DILATION_1, PADDING_1, STRIDE_1);
  localparam int LINES = lines_of(KERNEL_0, DILATION_0);
  localparam int CW    = idx_w(IN_WIDTH);
  localparam int RW    = idx_w(IN_HEIGHT);
  localparam int OCW   = idx_w(OUT_W);
  localparam int ORW   = idx_w(OUT_H);
  localparam int SW    = idx_w(LINES);
  // Slot of the (possibly negative) top row of output row 0.
  localparam int BASE0 = ((-PADDING_0 % LINES) + LINES) % LINES;

  state_t           r_state;
  logic             r_run, r_in_done, r_out_all, r_valid, r_last;
  logic [CW-1:0]    r_in_col;
  logic [RW-1:0]    r_in_row;
  logic [SW-1:0]    r_wr_slot, r_base_slot;
  logic [OCW-1:0]   r_out_col;
  logic [ORW-1:0]   r_out_row;
  logic [DW*KP-1:0] r_data;

  logic             w_in_fire, w_in_last, w_can_load, w_last_xfer, w_issue;
  logic             w_hazard, w_elig, w_win_last, w_frame_end;
  logic [SW-1:0]    w_base_next;
  logic [SW-1:0]    w_rd_slot [KP];
  logic [CW-1:0]    w_rd_col  [KP];
  logic [DW-1:0]    w_rd_data [KP];
  logic             w_inside  [KP];
  logic [DW*KP-1:0] w_win;

  assign w_in_fire   = i_valid && i_ready;
  assign w_in_last   = w_in_fire && (r_in_row == RW'(IN_HEIGHT - 1)) && (r_in_col == CW'(IN_WIDTH - 1));
  assign w_can_load  = !r_valid || pe_ack;
  assign w_last_xfer = r_valid && pe_ack && r_last;
  assign w_win_last  = (r_out_row == ORW'(OUT_H - 1)) && (r_out_col == OCW'(OUT_W - 1));
  assign w_issue     = r_run && w_can_load && !r_out_all && w_elig;
  // A frame closes once every pixel is in and the last window has left the output register.
  assign w_frame_end = (r_in_done || w_in_last) && r_out_all && (!r_valid || w_last_xfer);

  assign i_ready    = r_run && !r_in_done && !w_hazard;
  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign frame_done = w_last_xfer;

  // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
  always_comb begin : ctrl_comb
    int v_min_row, v_ry, v_rx, v_base;
    v_min_row = int'(r_out_row) * STRIDE_0 - PADDING_0;
    v_ry = v_min_row + DILATION_0 * (KERNEL_0 - 1);
    v_rx = int'(r_out_col) * STRIDE_1 - PADDING_1 + DILATION_1 * (KERNEL_1 - 1);
    if (v_ry > IN_HEIGHT - 1) v_ry = IN_HEIGHT - 1;
    if (v_ry < 0) v_ry = 0;
    if (v_rx > IN_WIDTH - 1) v_rx = IN_WIDTH - 1;
    if (v_rx < 0) v_rx = 0;
    // The incoming row would overwrite the oldest row the next window still needs.
    w_hazard = !r_out_all && (int'(r_in_row) >= v_min_row + LINES);
    w_elig   = r_in_done || (int'(r_in_row) > v_ry) ||
               ((int'(r_in_row) == v_ry) && (int'(r_in_col) > v_rx));
    v_base = int'(r_base_slot) + (STRIDE_0 % LINES);
    if (v_base >= LINES) v_base = v_base - LINES;
    w_base_next = SW'(v_base);
  end

  always_comb begin : addr_comb
    for (int ky = 0; ky < KERNEL_0; ky++) begin
      for (int kx = 0; kx < KERNEL_1; kx++) begin
        int v_row, v_col, v_slot;
        v_row  = int'(r_out_row) * STRIDE_0 - PADDING_0 + ky * DILATION_0;
        v_col  = int'(r_out_col) * STRIDE_1 - PADDING_1 + kx * DILATION_1;
        v_slot = int'(r_base_slot) + (ky * DILATION_0) % LINES;
        if (v_slot >= LINES) v_slot = v_slot - LINES;
        w_inside[ky*KERNEL_1+kx]  = (v_row >= 0) && (v_row < IN_HEIGHT) &&
                                    (v_col >= 0) && (v_col < IN_WIDTH);
        w_rd_slot[ky*KERNEL_1+kx] = SW'(v_slot);
        w_rd_col[ky*KERNEL_1+kx]  = w_inside[ky*KERNEL_1+kx] ? CW'(v_col) : '0;
      end
    end
  end

  always_comb begin : win_comb
    w_win = '0;
    for (int p = 0; p < KP; p++) if (w_inside[p]) w_win[p*DW +: DW] = w_rd_data[p];
  end

  line_buffer_ram #(
    .DW(DW), .LINES(LINES), .DEPTH(IN_WIDTH), .NRD(KP), .SW(SW), .CW(CW)
  ) u_ram (
    .clk       (clk),
    .i_we      (w_in_fire),
    .i_wr_slot (r_wr_slot),
    .i_wr_col  (r_in_col),
    .i_wr_data (i_data),
    .i_rd_slot (w_rd_slot),
    .i_rd_col  (w_rd_col),
    .o_rd_data (w_rd_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_run       <= 1'b0;
      r_in_done   <= 1'b0;
      r_out_all   <= 1'b0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_in_col    <= '0;
      r_in_row    <= '0;
      r_wr_slot   <= '0;
      r_base_slot <= SW'(BASE0);
      r_out_col   <= '0;
      r_out_row   <= '0;
      r_data      <= '0;
    end else begin
      r_run <= 1'b1;

      if (w_in_fire) begin
        if (r_in_col == CW'(IN_WIDTH - 1)) begin
          r_in_col <= '0;
          if (r_in_row == RW'(IN_HEIGHT - 1)) begin
            r_in_row  <= '0;
            r_wr_slot <= '0;
          end else begin
            r_in_row  <= r_in_row + RW'(1);
            r_wr_slot <= (r_wr_slot == SW'(LINES - 1)) ? '0 : r_wr_slot + SW'(1);
          end
        end else begin
          r_in_col <= r_in_col + CW'(1);
        end
      end

      if (w_issue) begin
        r_data  <= w_win;
        r_valid <= 1'b1;
        r_last  <= w_win_last;
        if (r_out_col == OCW'(OUT_W - 1)) begin
          r_out_col <= '0;
          if (r_out_row == ORW'(OUT_H - 1)) begin
            r_out_row   <= '0;
            r_base_slot <= SW'(BASE0);
          end else begin
            r_out_row   <= r_out_row + ORW'(1);
            r_base_slot <= w_base_next;
          end
        end else begin
          r_out_col <= r_out_col + OCW'(1);
        end
      end else if (w_can_load) begin
        r_valid <= 1'b0;
      end

      if (w_in_last) r_in_done <= 1'b1;
      if (w_issue && w_win_last) r_out_all <= 1'b1;

      if (w_frame_end) begin
        r_state   <= ST_IDLE;
        r_in_done <= 1'b0;
        r_out_all <= 1'b0;
      end else if (w_in_last) begin
        r_state <= ST_DRAIN;
      end else begin
        case (r_state)
          ST_IDLE: if (w_in_fire) r_state <= ST_FILL;
          ST_FILL: if (w_issue) r_state <= ST_EMIT;
          default: ;
        endcase
      end
    end
  end

endmodule
